// File: rtl/tohost_monitor.sv
// tohost_monitor
//   Completion checker for riscv-tests programs. Snoops the core's data
//   store port, keeps a shadow of the `tohost` word and decodes the exit
//   convention into pass / fail / timeout, plus the failing test number and
//   the number of cycles from reset release to completion.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_RUN     | test running; counter advancing, watching for an exit code
//   ST_PASS    | exit code 1 written; terminal until reset
//   ST_FAIL    | odd exit code other than 1 written; terminal until reset
//   ST_TIMEOUT | watchdog expired before any exit code; terminal until reset
//
// Ports
//   clk           core clock, rising edge
//   rst           asynchronous active-low reset
//   st_valid      store strobe
//   st_addr       store byte address
//   st_data       store data, lane-aligned
//   st_strb       byte-lane enables
//   done          finished for any reason
//   pass          finished with exit code 1
//   fail          finished with another odd exit code
//   timeout       watchdog expired
//   fail_test     exit code >> 1
//   cycles        cycles from reset release to completion
//   tohost_q      shadow copy of the tohost word
//   extra_writes  saturating count of tohost writes after done
module tohost_monitor #(
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [3:0]       st_strb,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [30:0]      fail_test,
    output logic [CNT_W-1:0] cycles,
    output logic [31:0]      tohost_q,
    output logic [7:0]       extra_writes
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYCLES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_cycles;
    logic [30:0]        r_fail_test;
    logic [31:0]        r_tohost;
    logic [7:0]         r_extra;

    logic               w_match;
    logic               w_wr;
    logic               w_term;
    logic               w_wdog;
    logic [31:0]        w_merged;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_unused_addr;

    // Word-granular match: the low address bits only select lanes.
    assign w_match       = st_valid && (st_addr[31:2] == TOHOST_ADDR[31:2]);
    assign w_unused_addr = &{1'b0, st_addr[1:0]};
    assign w_wr          = w_match && (st_strb != 4'h0);

    // Value the shadow takes after this cycle's merge; exit decode uses it.
    always_comb begin
        w_merged = r_tohost;
        for (int i = 0; i < 4; i++) begin
            if (w_match && st_strb[i]) begin
                w_merged[8*i +: 8] = st_data[8*i +: 8];
            end
        end
    end

    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_term    = w_wr && w_merged[0];
    assign w_wdog    = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == TO_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A terminating store beats a watchdog expiry in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_term) begin
                    w_state_nxt = (w_merged == 32'd1) ? ST_PASS : ST_FAIL;
                end else if (w_wdog) begin
                    w_state_nxt = ST_TIMEOUT;
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_cycles    <= '0;
            r_fail_test <= '0;
            r_tohost    <= '0;
            r_extra     <= '0;
        end else begin
            if (w_match) begin
                r_tohost <= w_merged;
            end
            if (r_state == ST_RUN) begin
                r_cnt <= w_cnt_inc;
                if (w_term) begin
                    r_cycles <= w_cnt_inc;
                    if (w_merged != 32'd1) begin
                        r_fail_test <= w_merged[31:1];
                    end
                end else if (w_wdog) begin
                    r_cycles <= TO_CNT;
                end
            end else if (w_wr && (r_extra != 8'hFF)) begin
                r_extra <= r_extra + 8'd1;
            end
        end
    end

    assign pass         = (r_state == ST_PASS);
    assign fail         = (r_state == ST_FAIL);
    assign timeout      = (r_state == ST_TIMEOUT);
    assign done         = pass | fail | timeout;
    assign fail_test    = r_fail_test;
    assign cycles       = r_cycles;
    assign tohost_q     = r_tohost;
    assign extra_writes = r_extra;

endmodule

// File: tb/tb_tohost_monitor.sv
module tb_tohost_monitor;

    localparam int TO = 50;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic        done, pass, fail, timeout;
    logic [30:0] fail_test;
    logic [31:0] cycles;
    logic [31:0] tohost_q;
    logic [7:0]  extra_writes;

    int total = 0;
    int bad   = 0;

    tohost_monitor #(
        .TOHOST_ADDR   (32'h0000_1000),
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_strb     (st_strb),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .fail_test   (fail_test),
        .cycles      (cycles),
        .tohost_q    (tohost_q),
        .extra_writes(extra_writes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: status 0=running 1=pass 2=fail 3=timeout.
    typedef struct {
        int          status;
        logic [31:0] tohost;
        logic [30:0] ft;
        logic [31:0] cyc;
        int          extra;
        int          elapsed;
    } model_t;

    model_t m;

    function automatic model_t step(model_t cur, logic v, logic [31:0] a,
                                    logic [31:0] d, logic [3:0] s);
        model_t n;
        logic   hit;
        logic   wr;
        n   = cur;
        hit = v && ((a >> 2) == (32'h0000_1000 >> 2));
        wr  = hit && (s != 4'h0);
        if (hit) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) n.tohost[8*i +: 8] = d[8*i +: 8];
        end
        if (cur.status == 0) begin
            n.elapsed = cur.elapsed + 1;
            if (wr && n.tohost[0]) begin
                n.status = (n.tohost == 32'd1) ? 1 : 2;
                if (n.status == 2) n.ft = n.tohost[31:1];
                n.cyc = n.elapsed;
            end else if (n.elapsed == TO) begin
                n.status = 3;
                n.cyc    = TO;
            end
        end else if (wr && cur.extra < 255) begin
            n.extra = cur.extra + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '{status: 0, tohost: 32'd0, ft: 31'd0, cyc: 32'd0, extra: 0, elapsed: 0};
        else      m <= step(m, st_valid, st_addr, st_data, st_strb);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("m_pass",      64'(pass),         64'(m.status == 1));
            chk("m_fail",      64'(fail),         64'(m.status == 2));
            chk("m_timeout",   64'(timeout),      64'(m.status == 3));
            chk("m_done",      64'(done),         64'(m.status != 0));
            chk("m_fail_test", 64'(fail_test),    64'(m.ft));
            chk("m_cycles",    64'(cycles),       64'(m.cyc));
            chk("m_tohost",    64'(tohost_q),     64'(m.tohost));
            chk("m_extra",     64'(extra_writes), 64'(m.extra));
        end
    end

    task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        st_strb  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_done",   64'(done),         64'd0);
        chk("rst_pass",   64'(pass),         64'd0);
        chk("rst_cycles", 64'(cycles),       64'd0);
        chk("rst_tohost", 64'(tohost_q),     64'd0);
        chk("rst_extra",  64'(extra_writes), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        int          len;
        rst      = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_strb  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Pass at cycle 20, then extra writes saturate.
        idle(19);
        cyc(1'b1, 32'h1000, 32'h1, 4'hF);
        chk("pass_done",   64'(done),     64'd1);
        chk("pass_pass",   64'(pass),     64'd1);
        chk("pass_fail",   64'(fail),     64'd0);
        chk("pass_cycles", 64'(cycles),   64'd20);
        chk("pass_tohost", 64'(tohost_q), 64'd1);
        for (int i = 0; i < 260; i++) cyc(1'b1, 32'h1000, 32'h7, 4'hF);
        chk("sat_extra", 64'(extra_writes), 64'd255);
        chk("sat_pass",  64'(pass),         64'd1);

        // Fail, then a later exit code does not change the verdict.
        do_reset();
        cyc(1'b1, 32'h1000, 32'h7, 4'hF);
        chk("fail_fail", 64'(fail),      64'd1);
        chk("fail_ft",   64'(fail_test), 64'd3);
        chk("fail_pass", 64'(pass),      64'd0);
        cyc(1'b1, 32'h1000, 32'h1, 4'hF);
        chk("fail_hold",  64'(fail),         64'd1);
        chk("fail_extra", 64'(extra_writes), 64'd1);

        // Partial writes.
        do_reset();
        cyc(1'b1, 32'h1000, 32'h0000_0100, 4'h2);
        chk("part_tohost", 64'(tohost_q), 64'h100);
        chk("part_done",   64'(done),     64'd0);
        cyc(1'b1, 32'h1000, 32'h0000_0005, 4'h1);
        chk("part_tohost2", 64'(tohost_q),  64'h105);
        chk("part_fail",    64'(fail),      64'd1);
        chk("part_ft",      64'(fail_test), 64'h82);

        // Address filtering.
        do_reset();
        cyc(1'b1, 32'h0FFC, 32'h1, 4'hF);
        cyc(1'b1, 32'h1004, 32'h1, 4'hF);
        cyc(1'b1, 32'h1000, 32'h1, 4'h0);
        chk("filt_done",   64'(done),     64'd0);
        chk("filt_tohost", 64'(tohost_q), 64'd0);
        cyc(1'b1, 32'h1002, 32'h1, 4'h1);
        chk("filt_pass", 64'(pass), 64'd1);

        // Watchdog, then exit code in the expiry cycle.
        do_reset();
        idle(TO - 1);
        chk("wd_early", 64'(done), 64'd0);
        idle(1);
        chk("wd_timeout", 64'(timeout), 64'd1);
        chk("wd_cycles",  64'(cycles),  64'd50);
        do_reset();
        idle(TO - 1);
        cyc(1'b1, 32'h1000, 32'h1, 4'hF);
        chk("wd_race_pass",    64'(pass),    64'd1);
        chk("wd_race_timeout", 64'(timeout), 64'd0);
        chk("wd_race_cycles",  64'(cycles),  64'd50);

        // Reset during PASS, then a fresh run.
        do_reset();
        chk("mid_done", 64'(done), 64'd0);
        cyc(1'b1, 32'h1000, 32'h3, 4'hF);
        chk("mid_fail", 64'(fail),      64'd1);
        chk("mid_ft",   64'(fail_test), 64'd1);

        // Randomized runs against the model.
        for (int r = 0; r < 40; r++) begin
            do_reset();
            len = $urandom_range(20, 90);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 149) == 0) do_reset();
                case ($urandom_range(0, 5))
                    0, 1, 2: a = 32'h1000 | 32'($urandom_range(0, 3));
                    3:       a = 32'h0FFC;
                    4:       a = 32'h1004;
                    default: a = $urandom;
                endcase
                case ($urandom_range(0, 3))
                    0:       d = 32'h1;
                    1:       d = $urandom & 32'hFFFF_FFFE;
                    2:       d = $urandom;
                    default: d = 32'($urandom_range(0, 15));
                endcase
                s = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
                cyc(($urandom_range(0, 3) == 0), a, d, s);
            end
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
